// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart transmitter among NREQ byte producers.
// Define UART_ARB_TAG_EN to prefix every granted byte with a TAG|index frame.
module uart_tx_arbiter #(
    parameter int          NREQ    = 4,
    parameter logic [15:0] TIMEOUT = 16'hFFFF,
    parameter logic [7:0]  TAG     = 8'hA0
) (
    input  logic              clk,
    input  logic              res_n,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] req_byte,
    output logic [NREQ-1:0]   ack,
    output logic              err,
    output logic              busy,
    output logic [2:0]        grant_idx,
    output logic [0:7]        tx_byte,
    output logic              stb,
    input  logic              tx_rdy
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_STB      = 3'd1,
        S_WAIT     = 3'd2,
        S_DONE     = 3'd3
`ifdef UART_ARB_TAG_EN
        ,
        S_TAG_STB  = 3'd4,
        S_TAG_WAIT = 3'd5
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q;
    logic [2:0]  ptr_q;
    logic [2:0]  gnt_idx;
    logic        gnt_vld;
    logic [7:0]  sel_byte;
    logic        grant;
    logic        abort;
    logic        tmo;
    logic [2:0]  nxt_ptr;
    logic [0:7]  first_byte;
`ifdef UART_ARB_TAG_EN
    logic [7:0]  data_q;
`endif

    // tx_byte is ascending-indexed: tx_byte[k] carries source bit k
    function automatic logic [0:7] to_tx(input logic [7:0] b);
        logic [0:7] r;
        for (int k = 0; k < 8; k++) r[k] = b[k];
        return r;
    endfunction

    // first set request scanning ptr, ptr+1, ...; reverse loop so lowest offset wins
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int off = NREQ - 1; off >= 0; off--) begin
            for (int i = 0; i < NREQ; i++) begin
                if (req[i] && ((int'(ptr_q) + off) % NREQ) == i) begin
                    gnt_vld = 1'b1;
                    gnt_idx = 3'(i);
                end
            end
        end
    end

    always_comb begin
        sel_byte = '0;
        for (int i = 0; i < NREQ; i++)
            if (gnt_idx == 3'(i)) sel_byte = req_byte[8*i +: 8];
    end

`ifdef UART_ARB_TAG_EN
    assign first_byte = to_tx(TAG | {5'b0, gnt_idx});
`else
    assign first_byte = to_tx(sel_byte);
`endif

    assign grant   = (state_q == S_IDLE) && tx_rdy && gnt_vld;
    assign tmo     = (cnt_q >= TIMEOUT - 16'd1);
    assign nxt_ptr = (grant_idx == 3'(NREQ - 1)) ? 3'd0 : grant_idx + 3'd1;

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            ptr_q     <= '0;
            grant_idx <= '0;
            tx_byte   <= '0;
            err       <= 1'b0;
`ifdef UART_ARB_TAG_EN
            data_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= (state_d != state_q || state_q == S_IDLE) ? 16'd0 : cnt_q + 16'd1;
            err     <= abort;
            if (grant) begin
                grant_idx <= gnt_idx;
                tx_byte   <= first_byte;
`ifdef UART_ARB_TAG_EN
                data_q    <= sel_byte;
`endif
            end
`ifdef UART_ARB_TAG_EN
            if (state_q == S_TAG_WAIT && state_d == S_STB) tx_byte <= to_tx(data_q);
`endif
            if (state_q == S_DONE || abort) ptr_q <= nxt_ptr;
        end
    end

    always_comb begin
        state_d = state_q;
        abort   = 1'b0;
        case (state_q)
            S_IDLE: begin
`ifdef UART_ARB_TAG_EN
                if (grant) state_d = S_TAG_STB;
`else
                if (grant) state_d = S_STB;
`endif
            end
`ifdef UART_ARB_TAG_EN
            S_TAG_STB: begin
                if (!tx_rdy)  state_d = S_TAG_WAIT;
                else if (tmo) begin state_d = S_IDLE; abort = 1'b1; end
            end
            S_TAG_WAIT: begin
                if (tx_rdy)   state_d = S_STB;
                else if (tmo) begin state_d = S_IDLE; abort = 1'b1; end
            end
`endif
            S_STB: begin
                if (!tx_rdy)  state_d = S_WAIT;
                else if (tmo) begin state_d = S_IDLE; abort = 1'b1; end
            end
            S_WAIT: begin
                if (tx_rdy)   state_d = S_DONE;
                else if (tmo) begin state_d = S_IDLE; abort = 1'b1; end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != S_IDLE);
        stb  = (state_q == S_STB);
`ifdef UART_ARB_TAG_EN
        if (state_q == S_TAG_STB) stb = 1'b1;
`endif
        for (int i = 0; i < NREQ; i++)
            ack[i] = (state_q == S_DONE) && (grant_idx == 3'(i));
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: behavioural uart model plus frame scoreboard.
module tb_uart_tx_arbiter;
    localparam int NREQ  = 4;
    localparam int FRAME = 8;

    logic              clk = 1'b0;
    logic              res_n = 1'b0;
    logic [NREQ-1:0]   req = '0;
    logic [8*NREQ-1:0] req_byte = '0;
    logic [NREQ-1:0]   ack;
    logic              err;
    logic              busy;
    logic [2:0]        grant_idx;
    logic [0:7]        tx_byte;
    logic              stb;
    logic              tx_rdy = 1'b1;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    bit  stuck = 1'b0;
    int  busy_cnt = 0;
    int  frame_cnt = 0;
    int  err_seen = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NREQ(NREQ), .TIMEOUT(16'd16), .TAG(8'hA0)) dut (
        .clk(clk), .res_n(res_n), .req(req), .req_byte(req_byte), .ack(ack),
        .err(err), .busy(busy), .grant_idx(grant_idx), .tx_byte(tx_byte),
        .stb(stb), .tx_rdy(tx_rdy)
    );

    // uart model: latches on stb while idle, then stays busy for FRAME cycles
    always @(negedge clk) begin : uart_model
        logic [7:0] b, e;
        if (!res_n) begin
            tx_rdy   = 1'b1;
            busy_cnt = 0;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) tx_rdy = 1'b1;
        end else if (stb && tx_rdy && !stuck) begin
            for (int k = 0; k < 8; k++) b[k] = tx_byte[k];
            frame_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL frame: got unexpected byte %02h, need none", b);
            end else begin
                e = exp_q.pop_front();
                if (b !== e) begin
                    errors++;
                    $display("FAIL frame: got %02h need %02h", b, e);
                end
            end
            tx_rdy   = 1'b0;
            busy_cnt = FRAME;
        end
    end

    always @(negedge clk) if (err === 1'b1) err_seen++;

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push_exp(input int idx, input logic [7:0] b);
`ifdef UART_ARB_TAG_EN
        exp_q.push_back(8'hA0 | 8'(idx));
`endif
        exp_q.push_back(b);
    endtask

    task automatic wait_ack(output logic [NREQ-1:0] a);
        a = '0;
        for (int n = 0; n < 300; n++) begin
            tick();
            if (ack !== '0) begin
                a = ack;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL wait_ack: got no ack in 300 cycles, need one");
    endtask

    task automatic test_reset();
        res_n = 1'b0;
        req   = '0;
        repeat (3) tick();
        checks++;
        if ({stb, busy, err, ack} !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs: got stb=%b busy=%b err=%b ack=%b, need 0", stb, busy, err, ack);
        end
        checks++;
        if (grant_idx !== 3'd0 || tx_byte !== 8'h00) begin
            errors++;
            $display("FAIL reset_regs: got grant_idx=%0d tx_byte=%b, need 0", grant_idx, tx_byte);
        end
        res_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        logic [NREQ-1:0] a;
        req_byte[15:8] = 8'h5A;
        push_exp(1, 8'h5A);
        req = 4'b0010;
        tick();
        checks++;
        if (stb !== 1'b1) begin
            errors++;
            $display("FAIL grant_latency: got stb=%b need 1", stb);
        end
        wait_ack(a);
        req = '0;
        checks++;
        if (a !== 4'b0010) begin errors++; $display("FAIL single_ack: got %b need 0010", a); end
        tick();
        checks++;
        if (ack !== 4'b0) begin errors++; $display("FAIL ack_width: got %b need 0000", ack); end
        checks++;
        if (dut.ptr_q !== 3'd2) begin errors++; $display("FAIL single_ptr: got %0d need 2", dut.ptr_q); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL single_frames: got %0d left need 0", exp_q.size()); end
    endtask

    task automatic test_all_four();
        logic [NREQ-1:0] a;
        res_n    = 1'b0;
        err_seen = 0;
        req_byte = 32'h13121110;
        req      = 4'b1111;
        for (int i = 0; i < 4; i++) push_exp(i, 8'h10 + 8'(i));
        tick();
        res_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_ack(a);
            req[i] = 1'b0;
            checks++;
            if (a !== 4'(1 << i)) begin errors++; $display("FAIL all4_ack%0d: got %b need %b", i, a, 4'(1 << i)); end
        end
        checks++;
        if (exp_q.size() != 0 || err_seen != 0) begin
            errors++;
            $display("FAIL all4_done: got left=%0d err=%0d need 0/0", exp_q.size(), err_seen);
        end
    endtask

    task automatic test_fairness();
        logic [NREQ-1:0] a;
        logic [NREQ-1:0] order[4] = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
        req_byte = 32'h00220020;
        for (int i = 0; i < 4; i++) push_exp(order[i] == 4'b0001 ? 0 : 2, order[i] == 4'b0001 ? 8'h20 : 8'h22);
        req = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            wait_ack(a);
            if (i == 3) req = '0;
            checks++;
            if (a !== order[i]) begin errors++; $display("FAIL fair_ack%0d: got %b need %b", i, a, order[i]); end
        end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL fair_frames: got %0d left need 0", exp_q.size()); end
    endtask

    task automatic test_timeout();
        int  stb_cyc = 0;
        bit  got_err = 1'b0;
        bit  got_ack = 1'b0;
        stuck    = 1'b1;
        req_byte = 32'h00000077;
        req      = 4'b0001;
        for (int n = 0; n < 100 && !got_err; n++) begin
            tick();
            if (stb === 1'b1) stb_cyc++;
            if (ack !== '0) got_ack = 1'b1;
            if (err === 1'b1) got_err = 1'b1;
        end
        req = '0;
        checks++;
        if (!got_err) begin errors++; $display("FAIL tmo_err: got no err need pulse"); end
        checks++;
        if (stb_cyc != 16) begin errors++; $display("FAIL tmo_stb_len: got %0d need 16", stb_cyc); end
        checks++;
        if (busy !== 1'b0 || stb !== 1'b0 || got_ack) begin
            errors++;
            $display("FAIL tmo_state: got busy=%b stb=%b ack_seen=%b need 0/0/0", busy, stb, got_ack);
        end
        tick();
        checks++;
        if (err !== 1'b0 || dut.ptr_q !== 3'd1) begin
            errors++;
            $display("FAIL tmo_after: got err=%b ptr=%0d need 0/1", err, dut.ptr_q);
        end
        stuck = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_reset_wait();
        logic [NREQ-1:0] a;
        bit in_wait = 1'b0;
        req_byte = 32'h00990000;
        push_exp(2, 8'h99);
        req = 4'b0100;
        for (int n = 0; n < 100 && !in_wait; n++) begin
            tick();
            if (busy === 1'b1 && stb === 1'b0 && tx_rdy === 1'b0) in_wait = 1'b1;
        end
        checks++;
        if (!in_wait) begin errors++; $display("FAIL rst_reach_wait: got no wait state need one"); end
        res_n = 1'b0;
        #1;
        checks++;
        if ({stb, busy, err, ack} !== 7'b0) begin
            errors++;
            $display("FAIL rst_midxfer: got stb=%b busy=%b err=%b ack=%b need 0", stb, busy, err, ack);
        end
        exp_q.delete();
        req = '0;
        repeat (2) tick();
        res_n = 1'b1;
        tick();
        checks++;
        if (dut.ptr_q !== 3'd0) begin errors++; $display("FAIL rst_ptr: got %0d need 0", dut.ptr_q); end
        req_byte = 32'h00330031;
        push_exp(0, 8'h31);
        push_exp(2, 8'h33);
        req = 4'b0101;
        wait_ack(a);
        req[0] = 1'b0;
        checks++;
        if (a !== 4'b0001) begin errors++; $display("FAIL rst_regrant0: got %b need 0001", a); end
        wait_ack(a);
        req = '0;
        checks++;
        if (a !== 4'b0100) begin errors++; $display("FAIL rst_regrant2: got %b need 0100", a); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL rst_frames: got %0d left need 0", exp_q.size()); end
    endtask

`ifdef UART_ARB_TAG_EN
    task automatic test_tag();
        logic [NREQ-1:0] a;
        int f0;
        f0       = frame_cnt;
        req_byte = 32'hC3000000;
        push_exp(3, 8'hC3);
        req = 4'b1000;
        wait_ack(a);
        req = '0;
        checks++;
        if (a !== 4'b1000) begin errors++; $display("FAIL tag_ack: got %b need 1000", a); end
        checks++;
        if (frame_cnt - f0 != 2 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL tag_frames: got %0d frames, %0d left, need 2/0", frame_cnt - f0, exp_q.size());
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_all_four();
        test_fairness();
        test_timeout();
        test_reset_wait();
`ifdef UART_ARB_TAG_EN
        test_tag();
`endif
        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
